// File: rtl/dm_arb_pkg.sv
// ============================================================================
// Module  : dm_arb_pkg
// Purpose : Shared types and constants for the data-memory arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int N_CORES_DEF = 4;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 16;
    localparam int STAT_W      = 16;

    // Index width that stays legal even for a single-core build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin selector; searches upward from last+1.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int IW      = idx_w(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    int w_best;
    int w_dist;

    // Distance from the slot after the last grant; the smallest requesting distance wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_best = N_CORES;
        w_dist = 0;
        for (int j = 0; j < N_CORES; j++) begin
            w_dist = (j + N_CORES - int'(last) - 1) % N_CORES;
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                winner = IW'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module  : dm_arbiter
// Purpose : Round-robin sharing of a single-port synchronous data memory.
//           Optional per-core grant counters enabled by DM_ARB_STATS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DM_ARB_STATS_EN
    output logic [N_CORES*STAT_W-1:0] grant_cnt,
`endif
    input  logic [N_CORES-1:0]    req,
    input  logic [N_CORES-1:0]    we,
    input  logic [N_CORES*AW-1:0] addr,
    input  logic [N_CORES*DW-1:0] wdata,
    output logic [N_CORES-1:0]    done,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         dm_addr,
    output logic [DW-1:0]         dm_wdata,
    output logic                  dm_we,
    input  logic [DW-1:0]         dm_rdata,
    output logic                  busy
);

    localparam int IW = idx_w(N_CORES);

    state_t        r_state;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_last;
    logic          r_wr;
    logic [IW-1:0] w_winner;
    logic          w_valid;

    rr_pick #(
        .N_CORES (N_CORES),
        .IW      (IW)
    ) u_rr_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_last   <= IW'(N_CORES - 1);
            r_wr     <= 1'b0;
            done     <= '0;
            rdata    <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_we    <= 1'b0;
        end else begin
            done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner  <= w_winner;
                        r_wr     <= we[w_winner];
                        dm_addr  <= addr[int'(w_winner)*AW +: AW];
                        dm_wdata <= wdata[int'(w_winner)*DW +: DW];
                        dm_we    <= we[w_winner];
                        r_state  <= ACCESS;
                    end else begin
                        dm_we    <= 1'b0;
                    end
                end
                ACCESS: begin
                    dm_we   <= 1'b0;
                    r_state <= RESP;
                end
                RESP: begin
                    // Memory output is valid here, one cycle after the address was presented.
                    if (!r_wr) begin
                        rdata <= dm_rdata;
                    end
                    done    <= N_CORES'(1) << r_owner;
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    dm_we   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);

`ifdef DM_ARB_STATS_EN
    for (genvar g = 0; g < N_CORES; g++) begin : g_stats
        logic [STAT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (done[g] && (r_cnt != {STAT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[g*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module  : tb_dm_arbiter
// Purpose : Directed self-checking bench for dm_arbiter with a behavioural DM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we  = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic            dm_we;
    logic [DW-1:0]   dm_rdata = '0;
    logic            busy;
`ifdef DM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    logic            pre_we   = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [DW-1:0]   pre_data = '0;
    logic [DW-1:0]   mem [256];
    int              we_hi = 0;
    int              passed = 0;
    int              total  = 0;
    int              we_base;

    always #5 clk = ~clk;

    dm_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DM_ARB_STATS_EN
        .grant_cnt(grant_cnt),
`endif
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .done     (done),
        .rdata    (rdata),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata),
        .busy     (busy)
    );

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (dm_we)       mem[dm_addr]  <= dm_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        dm_rdata <= mem[dm_addr];
        if (dm_we) we_hi <= we_hi + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic run(input int core, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input string tag);
        req = '0;
        we  = '0;
        req[core] = 1'b1;
        we[core]  = wr;
        addr[core*AW +: AW]  = a;
        wdata[core*DW +: DW] = d;
        step();
        chk({tag, "_addr"}, 32'(dm_addr), 32'(a));
        chk({tag, "_we"},   32'(dm_we),   32'(wr));
        step();
        chk({tag, "_we_clr"}, 32'(dm_we), 32'd0);
        step();
        chk({tag, "_done"},  32'(done),  32'(1) << core);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        req = '0;
        we  = '0;
    endtask

    initial begin
        // Reset and preload the memory.
        pre_we = 1'b1; pre_addr = 8'h05; pre_data = 16'h1234;
        step();
        pre_we = 1'b0;
        step();
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_rdata", 32'(rdata),    32'd0);
        chk("rst_addr",  32'(dm_addr),  32'd0);
        chk("rst_we",    32'(dm_we),    32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        rst = 1'b0;

        // Single read by core 0.
        we_base = we_hi;
        run(0, 1'b0, 8'h05, 16'h0000, 16'h1234, "rd0");
        chk("rd0_we_cycles", 32'(we_hi - we_base), 32'd0);

        // Write by core 2, then read back by core 1.
        we_base = we_hi;
        run(2, 1'b1, 8'h10, 16'hBEEF, 16'h1234, "wr2");
        chk("wr2_we_cycles", 32'(we_hi - we_base), 32'd1);
        run(1, 1'b0, 8'h10, 16'h0000, 16'hBEEF, "rd1");

        // Fairness: all cores request continuously from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        we  = '0;
        for (int s = 1; s <= 15; s++) begin
            step();
            chk($sformatf("fair_s%0d", s), 32'(done),
                (s % 3 == 0) ? (32'(1) << ((s / 3 - 1) % 4)) : 32'd0);
        end
        req = '0;

        // Late arrival: core 3 requests while core 1 is in ACCESS.
        req[1] = 1'b1; addr[1*AW +: AW] = 8'h10;
        step();
        chk("late_c1_addr", 32'(dm_addr), 32'h10);
        chk("late_busy",    32'(busy),    32'd1);
        req[3] = 1'b1; addr[3*AW +: AW] = 8'h05;
        step();
        chk("late_c1_addr_held", 32'(dm_addr), 32'h10);
        step();
        chk("late_c1_done",  32'(done),  32'b0010);
        chk("late_c1_rdata", 32'(rdata), 32'hBEEF);
        req[1] = 1'b0;
        step();
        chk("late_c3_addr", 32'(dm_addr), 32'h05);
        step();
        step();
        chk("late_c3_done",  32'(done),  32'b1000);
        chk("late_c3_rdata", 32'(rdata), 32'h1234);
        req = '0;

        // Reset while a core-0 write is in ACCESS.
        req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = 8'h20; wdata[0 +: DW] = 16'hCAFE;
        step();
        chk("mid_we", 32'(dm_we), 32'd1);
        rst = 1'b1;
        req = '0;
        we  = '0;
        step();
        chk("mid_done",  32'(done),     32'd0);
        chk("mid_we_0",  32'(dm_we),    32'd0);
        chk("mid_busy",  32'(busy),     32'd0);
        chk("mid_addr",  32'(dm_addr),  32'd0);
        chk("mid_wdata", 32'(dm_wdata), 32'd0);
        chk("mid_rdata", 32'(rdata),    32'd0);
        rst = 1'b0;
        step();
        step();
        chk("mid_no_done", 32'(done), 32'd0);
        chk("mid_idle",    32'(busy), 32'd0);

`ifdef DM_ARB_STATS_EN
        for (int k = 0; k < 5; k++) run(1, 1'b0, 8'h05, 16'h0, 16'h1234, "st1");
        for (int k = 0; k < 2; k++) run(0, 1'b0, 8'h10, 16'h0, 16'hBEEF, "st0");
        step();
        chk("stat_c1", 32'(grant_cnt[1*16 +: 16]), 32'd5);
        chk("stat_c0", 32'(grant_cnt[0*16 +: 16]), 32'd2);
        chk("stat_c2", 32'(grant_cnt[2*16 +: 16]), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stat_rst", 32'(grant_cnt[31:0]), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
